// File: rtl/params_pkg.sv
// Shared parameters for the Barrett reduction datapath and the stream driver FSM encoding.
package params_pkg;

   localparam int DATA_LENGTH = 32;
   localparam int MODULUS     = 8380417;
   // floor(2^46 / MODULUS), the Barrett constant for a 23-bit modulus
   localparam int MU          = 8396807;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      FIN   = 2'd3
   } drv_state_t;

endpackage

// File: rtl/barrett_stream_driver_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port with a cleared output on reset.
module sdp_ram
   import params_pkg::*;
#(
   parameter int W     = DATA_LENGTH,
   parameter int DEPTH = 256,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          wr_en_i,
   input  logic [AW-1:0] wr_addr_i,
   input  logic [W-1:0]  wr_data_i,
   input  logic [AW-1:0] rd_addr_i,
   output logic [W-1:0]  rd_data_o
);

   logic [W-1:0] mem [DEPTH];
   logic [W-1:0] rd_data_d;
   logic [W-1:0] rd_data_q;

   always_ff @(posedge clk_i) begin
      if (wr_en_i) begin
         mem[wr_addr_i] <= wr_data_i;
      end
   end

   always_comb begin
      rd_data_d = mem[rd_addr_i];
   end

   // Only the read register is reset; array contents survive reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rd_data_q <= '0;
      end else begin
         rd_data_q <= rd_data_d;
      end
   end

   assign rd_data_o = rd_data_q;

endmodule

// File: rtl/barrett_stream_driver.sv
// Batch initiator/collector for the pipelined Barrett reducer: streams an input buffer into the
// reducer one word per cycle and gathers the in-order results into an output buffer.
module barrett_stream_driver #(
   parameter int DATA_LENGTH = params_pkg::DATA_LENGTH,
   parameter int DEPTH       = 256,
   parameter int AW          = $clog2(DEPTH),
   parameter int TIMEOUT     = 64
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   wr_en_i,
   input  logic [AW-1:0]          wr_addr_i,
   input  logic [DATA_LENGTH-1:0] wr_data_i,
   input  logic [AW:0]            len_i,
   input  logic                   go_i,
   output logic                   busy_o,
   output logic                   done_o,
   output logic                   err_o,
   output logic                   red_start_o,
   output logic [DATA_LENGTH-1:0] red_x_o,
   input  logic                   red_valid_i,
   input  logic [DATA_LENGTH-1:0] red_result_i,
   input  logic [AW-1:0]          rd_addr_i,
   output logic [DATA_LENGTH-1:0] rd_data_o
);

   import params_pkg::*;

   localparam int CW  = AW + 1;
   localparam int WDW = $clog2(TIMEOUT + 1);

   drv_state_t      state_q, state_d;
   logic [CW-1:0]   len_q, len_d;
   logic [CW-1:0]   icnt_q, icnt_d;
   logic [CW-1:0]   rcnt_q, rcnt_d;
   logic [WDW-1:0]  wdog_q, wdog_d;
   logic            err_q, err_d;
   logic            start_q, start_d;

   logic                   busy;
   logic                   collecting;
   logic                   accept;
   logic                   timeout;
   logic                   in_we;
   logic [DATA_LENGTH-1:0] in_rd_data;

   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      icnt_d     = icnt_q;
      rcnt_d     = rcnt_q;
      wdog_d     = wdog_q;
      err_d      = err_q;
      start_d    = 1'b0;

      busy       = (state_q != IDLE);
      in_we      = wr_en_i && !busy;
      collecting = (state_q == ISSUE) || (state_q == DRAIN);
      accept     = collecting && red_valid_i && (rcnt_q != len_q);
      timeout    = collecting && !red_valid_i && (wdog_q == WDW'(TIMEOUT - 1));

      if (accept) begin
         rcnt_d = rcnt_q + CW'(1);
      end

      if (collecting) begin
         wdog_d = red_valid_i ? '0 : wdog_q + WDW'(1);
      end

      case (state_q)
         IDLE: begin
            if (go_i) begin
               err_d  = 1'b0;
               icnt_d = '0;
               rcnt_d = '0;
               wdog_d = '0;
               if (len_i == '0) begin
                  state_d = FIN;
               end else begin
                  len_d   = len_i;
                  state_d = ISSUE;
               end
            end
         end
         ISSUE: begin
            icnt_d = icnt_q + CW'(1);
            if (timeout) begin
               err_d   = 1'b1;
               state_d = FIN;
            end else begin
               start_d = 1'b1;
               // A short-latency reducer may deliver the last result alongside the last issue.
               if (icnt_d == len_q) begin
                  state_d = (rcnt_d == len_q) ? FIN : DRAIN;
               end
            end
         end
         DRAIN: begin
            if (timeout) begin
               err_d   = 1'b1;
               state_d = FIN;
            end else if (rcnt_d == len_q) begin
               state_d = FIN;
            end
         end
         FIN: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Results outside a batch, or beyond its length, are dropped and flagged.
      if (red_valid_i && !accept) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         len_q   <= '0;
         icnt_q  <= '0;
         rcnt_q  <= '0;
         wdog_q  <= '0;
         err_q   <= 1'b0;
         start_q <= 1'b0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         icnt_q  <= icnt_d;
         rcnt_q  <= rcnt_d;
         wdog_q  <= wdog_d;
         err_q   <= err_d;
         start_q <= start_d;
      end
   end

   sdp_ram #(
      .W     (DATA_LENGTH),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_inbuf (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .wr_en_i   (in_we),
      .wr_addr_i (wr_addr_i),
      .wr_data_i (wr_data_i),
      .rd_addr_i (icnt_q[AW-1:0]),
      .rd_data_o (in_rd_data)
   );

   sdp_ram #(
      .W     (DATA_LENGTH),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_outbuf (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .wr_en_i   (accept),
      .wr_addr_i (rcnt_q[AW-1:0]),
      .wr_data_i (red_result_i),
      .rd_addr_i (rd_addr_i),
      .rd_data_o (rd_data_o)
   );

   assign busy_o      = busy;
   assign done_o      = (state_q == FIN);
   assign err_o       = err_q;
   assign red_start_o = start_q;
   assign red_x_o     = start_q ? in_rd_data : '0;

endmodule

// File: tb/tb_barrett_stream_driver.sv
// Directed bench for barrett_stream_driver with a 3-stage behavioural reducer stub (x mod q).
module tb_barrett_stream_driver;

   localparam int DL    = 32;
   localparam int DEPTH = 256;
   localparam int AW    = 8;
   localparam int L     = 3;
   localparam logic [DL-1:0] MODV = 32'd8380417;

   logic          clk = 1'b0;
   logic          rst;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [DL-1:0] wr_data;
   logic [AW:0]   len;
   logic          go;
   logic          busy, done, err;
   logic          red_start;
   logic [DL-1:0] red_x;
   logic          red_valid;
   logic [DL-1:0] red_result;
   logic [AW-1:0] rd_addr;
   logic [DL-1:0] rd_data;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   barrett_stream_driver #(
      .DATA_LENGTH (DL),
      .DEPTH       (DEPTH),
      .AW          (AW),
      .TIMEOUT     (64)
   ) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .wr_en_i      (wr_en),
      .wr_addr_i    (wr_addr),
      .wr_data_i    (wr_data),
      .len_i        (len),
      .go_i         (go),
      .busy_o       (busy),
      .done_o       (done),
      .err_o        (err),
      .red_start_o  (red_start),
      .red_x_o      (red_x),
      .red_valid_i  (red_valid),
      .red_result_i (red_result),
      .rd_addr_i    (rd_addr),
      .rd_data_o    (rd_data)
   );

   // Reducer stub: fixed latency, optional drop of the 3rd result, optional injected valid.
   logic [L-1:0]  pv = '0;
   logic [DL-1:0] pd [L];
   int            stub_cnt = 0;
   logic          drop_en = 1'b0;
   logic          inj = 1'b0;

   always @(posedge clk) begin
      pv    <= {pv[L-2:0], red_start};
      pd[0] <= red_x % MODV;
      for (int i = 1; i < L; i++) pd[i] <= pd[i-1];
      if (!busy) stub_cnt <= 0;
      else if (pv[L-1]) stub_cnt <= stub_cnt + 1;
   end

   assign red_valid  = (pv[L-1] && !(drop_en && stub_cnt == 2)) || inj;
   assign red_result = pd[L-1];

   typedef struct {
      logic [DL-1:0] x;
      logic [DL-1:0] r;
   } vec_t;

   vec_t          tbl [8];
   logic [DL-1:0] rnd_exp [DEPTH];

   task automatic chk(input string name, input longint act, input longint req);
      n_cmp++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input int addr, input logic [DL-1:0] data);
      wr_en   = 1'b1;
      wr_addr = AW'(addr);
      wr_data = data;
      step();
      wr_en   = 1'b0;
   endtask

   task automatic rd(input int addr, output logic [DL-1:0] data);
      rd_addr = AW'(addr);
      step();
      data = rd_data;
   endtask

   // Issues go and observes the batch; k counts edges after the go edge (k=0 is the go edge).
   task automatic run_batch(input int n, input int budget, output int beats, output int first_k,
                            output int last_k, output int done_k, output int done_n,
                            output int busy_n, output logic err_done);
      beats = 0; first_k = -1; last_k = -1; done_k = -1; done_n = 0; busy_n = 0; err_done = 1'b0;
      len = (AW+1)'(n);
      go  = 1'b1;
      for (int k = 0; k <= budget; k++) begin
         step();
         go = 1'b0;
         if (busy) busy_n++;
         if (red_start) begin
            beats++;
            if (first_k < 0) first_k = k;
            last_k = k;
         end
         if (done) begin
            done_n++;
            if (done_k < 0) begin
               done_k   = k;
               err_done = err;
            end
         end
         if (done_k >= 0 && k >= done_k + 2) break;
      end
   endtask

   task automatic check_batch(input string tag, input int n, input int exp_done_k, input logic exp_err);
      int beats, first_k, last_k, done_k, done_n, busy_n;
      logic err_done;
      run_batch(n, n + 200, beats, first_k, last_k, done_k, done_n, busy_n, err_done);
      chk({tag, "_done_at"}, done_k, exp_done_k);
      chk({tag, "_done_count"}, done_n, 1);
      chk({tag, "_beats"}, beats, n);
      if (n > 0) begin
         chk({tag, "_first_beat"}, first_k, 1);
         chk({tag, "_last_beat"}, last_k, n);
      end
      chk({tag, "_busy_cycles"}, busy_n, exp_done_k + 1);
      chk({tag, "_err_at_done"}, err_done, exp_err);
   endtask

   initial begin
      logic [DL-1:0] v;
      int beats;

      tbl[0] = '{x: 32'd0,          r: 32'd0};
      tbl[1] = '{x: 32'd8380417,    r: 32'd0};
      tbl[2] = '{x: 32'd8380418,    r: 32'd1};
      tbl[3] = '{x: 32'd16760833,   r: 32'd8380416};
      tbl[4] = '{x: 32'd8380416,    r: 32'd8380416};
      tbl[5] = '{x: 32'hFFFF_FFFF,  r: 32'd4193791};
      tbl[6] = '{x: 32'd25141252,   r: 32'd1};
      tbl[7] = '{x: 32'd12345,      r: 32'd12345};

      rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; len = '0; go = 1'b0; rd_addr = '0;
      step(); step();
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_start", red_start, 0);
      chk("rst_x", red_x, 0);
      chk("rst_rd_data", rd_data, 0);
      rst = 1'b0;
      step();

      // Four-word batch from the first table rows
      for (int i = 0; i < 4; i++) load(i, tbl[i].x);
      check_batch("b4", 4, 4 + L + 1, 1'b0);
      for (int i = 0; i < 4; i++) begin
         rd(i, v);
         chk($sformatf("b4_out%0d", i), v, tbl[i].r);
      end

      // Full table as an eight-word batch
      for (int i = 0; i < 8; i++) load(i, tbl[i].x);
      check_batch("b8", 8, 8 + L + 1, 1'b0);
      for (int i = 0; i < 8; i++) begin
         rd(i, v);
         chk($sformatf("b8_out%0d", i), v, tbl[i].r);
      end

      check_batch("len0", 0, 0, 1'b0);

      // Stub drops the 3rd result: timeout 64 edges after the last valid result
      drop_en = 1'b1;
      check_batch("drop", 4, 4 + L + 1 + 64, 1'b1);
      drop_en = 1'b0;
      step();
      chk("drop_err_sticky", err, 1);

      // Reset after three issued beats, then recover with a two-word batch
      load(0, 32'd8380419);
      load(1, 32'd100);
      len = 9'd4;
      go  = 1'b1;
      step();
      go = 1'b0;
      beats = 0;
      for (int k = 1; k <= 3; k++) begin
         step();
         if (red_start) beats++;
      end
      chk("rstmid_beats", beats, 3);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rstmid_start", red_start, 0);
      chk("rstmid_busy", busy, 0);
      chk("rstmid_done", done, 0);
      for (int k = 0; k < 10; k++) step();
      chk("rstmid_late_err", err, 1);
      check_batch("recov", 2, 2 + L + 1, 1'b0);
      rd(0, v);
      chk("recov_out0", v, 2);
      rd(1, v);
      chk("recov_out1", v, 100);

      // Spurious valid while idle, then an honoured go clears err
      inj = 1'b1;
      step();
      inj = 1'b0;
      chk("inj_err", err, 1);
      step();
      chk("inj_err_hold", err, 1);
      len = 9'd2;
      go  = 1'b1;
      step();
      go = 1'b0;
      chk("inj_go_clears", err, 0);
      for (int k = 0; k < 20; k++) step();
      chk("inj_batch_err", err, 0);

      // Full-depth batch of random words
      for (int i = 0; i < DEPTH; i++) begin
         v = $urandom;
         rnd_exp[i] = v % MODV;
         load(i, v);
      end
      check_batch("b256", DEPTH, DEPTH + L + 1, 1'b0);
      for (int i = 0; i < DEPTH; i++) begin
         rd(i, v);
         chk($sformatf("b256_out%0d", i), v, rnd_exp[i]);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
